// File: rtl/pb_debouncer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pb_debouncer_multi
//  Purpose  : N-channel push-button conditioner. Each channel has a 2-flop
//             synchroniser, press/release debounce, per-channel polarity,
//             long-press and auto-repeat event generation.
//  Ports    : clk                - sole clock
//             rst                - asynchronous active-low reset
//             PB[N_CH]           - raw asynchronous button pins
//             PB_pressed_status  - level, channel considered pressed
//             PB_pressed_pulse   - one-cycle pulse on accepted press
//             PB_released_pulse  - one-cycle pulse on accepted release
//             PB_long_pulse      - one-cycle pulse when hold hits LONG_DELAY
//             PB_repeat_pulse    - one-cycle pulse every REPEAT_PERIOD after long
//             any_pressed        - OR of PB_pressed_status
//  Revision : 1.0 - initial release
// ============================================================================
module pb_debouncer_multi #(
  parameter int              N_CH          = 4,
  parameter int              DELAY         = 10,
  parameter int              LONG_DELAY    = 50000,
  parameter int              REPEAT_PERIOD = 10000,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] PB_pressed_status,
  output logic [N_CH-1:0] PB_pressed_pulse,
  output logic [N_CH-1:0] PB_released_pulse,
  output logic [N_CH-1:0] PB_long_pulse,
  output logic [N_CH-1:0] PB_repeat_pulse,
  output logic            any_pressed
);

  localparam int TMR_W  = $clog2(DELAY);
  localparam int HOLD_W = (LONG_DELAY > 0) ? $clog2(LONG_DELAY + 1) : 1;
  localparam int REP_W  = (REPEAT_PERIOD > 0) ? $clog2(REPEAT_PERIOD + 1) : 1;

  // Long-press disabled also disables repeat, since repeat is armed by long.
  localparam bit LONG_EN = (LONG_DELAY > 0);
  localparam bit REP_EN  = LONG_EN && (REPEAT_PERIOD > 0);

  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_EN ? LONG_DELAY - 1 : 0);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REP_EN ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COUNT_P  = 3'd1,
    S_PRESSED  = 3'd2,
    S_HELD     = 3'd3,
    S_COUNT_R  = 3'd4,
    S_RELEASED = 3'd5
  } state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              act_raw;
    logic              sync1_q;
    logic              act_q;
    state_e            state_q,     state_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [REP_W-1:0]  rep_q,       rep_d;
    logic              long_done_q, long_done_d;
    logic              long_evt;

    // Polarity is folded in before synchronising so reset (flops at 0)
    // always reads as "not pressed" regardless of pin polarity.
    assign act_raw = PB[i] ^ ACTIVE_LOW[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q     <= 1'b0;
        act_q       <= 1'b0;
        state_q     <= S_IDLE;
        timer_q     <= '0;
        hold_q      <= '0;
        rep_q       <= '0;
        long_done_q <= 1'b0;
      end else begin
        sync1_q     <= act_raw;
        act_q       <= sync1_q;
        state_q     <= state_d;
        timer_q     <= timer_d;
        hold_q      <= hold_d;
        rep_q       <= rep_d;
        long_done_q <= long_done_d;
      end
    end

    // long_done_q guards against re-firing while hold_q sits saturated.
    assign long_evt = LONG_EN && (state_q == S_HELD) && !long_done_q &&
                      (hold_q == HOLD_MAX) && act_q;

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:     if (act_q) state_d = S_COUNT_P;
        S_COUNT_P: begin
          if (!act_q)                  state_d = S_IDLE;
          else if (timer_q == TMR_MAX) state_d = S_PRESSED;
        end
        S_PRESSED:  state_d = S_HELD;
        S_HELD:     if (!act_q) state_d = S_COUNT_R;
        S_COUNT_R: begin
          if (act_q)                   state_d = S_HELD;
          else if (timer_q == TMR_MAX) state_d = S_RELEASED;
        end
        S_RELEASED: state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end

    // Hold/repeat counters only move in HELD, so a release bounce through
    // COUNT_R freezes them and they resume on return to HELD.
    always_comb begin
      timer_d     = (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
      hold_d      = hold_q;
      rep_d       = rep_q;
      long_done_d = long_done_q;
      if (state_q == S_PRESSED) begin
        hold_d      = '0;
        long_done_d = 1'b0;
      end else if (state_q == S_HELD) begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
        if (long_evt) begin
          long_done_d = 1'b1;
          rep_d       = '0;
        end else if (long_done_q) begin
          rep_d = (rep_q == REP_MAX) ? '0 : rep_q + REP_W'(1);
        end
      end
    end

    assign PB_pressed_status[i] = (state_q == S_PRESSED) || (state_q == S_HELD) ||
                                  (state_q == S_COUNT_R);
    assign PB_pressed_pulse[i]  = (state_q == S_PRESSED);
    assign PB_released_pulse[i] = (state_q == S_RELEASED);
    assign PB_long_pulse[i]     = long_evt;
    assign PB_repeat_pulse[i]   = REP_EN && (state_q == S_HELD) && long_done_q &&
                                  (rep_q == REP_MAX) && act_q;
  end

  assign any_pressed = |PB_pressed_status;

endmodule
`default_nettype wire
